hdlc_rx_deframer: RTL and testbench

HDLC_RX_DEFRAMER -- requirements
Module: hdlc_rx_deframer

---
 rtl/hdlc_pkg.sv | 27 ++
 rtl/hdlc_rx_flag_detect.sv | 48 ++++
 rtl/hdlc_rx_deframer.sv | 173 +++++++++++++++++
 tb/tb_hdlc_rx_deframer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_pkg.sv
// Shared definitions for the HDLC receive path: flag pattern, frame length
// limit, receiver state encoding and the saturating ones-run helper.
package hdlc_pkg;

    localparam logic [7:0] HDLC_FLAG       = 8'h7E;
    localparam logic [7:0] MAX_FRAME_BYTES = 8'd128;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SYNC  = 2'd1,
        FRAME = 2'd2
    } rx_state_e;

    // Length of the current run of ones after one more line bit, held at 7
    function automatic logic [2:0] ones_next(input logic [2:0] ones, input logic line_bit);
        logic [2:0] result;
        if (!line_bit) begin
            result = 3'd0;
        end else if (ones == 3'd7) begin
            result = 3'd7;
        end else begin
            result = ones + 3'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hdlc_rx_flag_detect.sv
// Line-bit classifier: keeps the 8-bit arrival window (live bit plus seven
// registered bits) and the ones-run counter, and flags the current bit as the
// end of a flag, the seventh consecutive one (abort) or a stuffed zero.
module hdlc_rx_flag_detect
    import hdlc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bit_en,
    input  logic rx_bit,
    output logic flag_hit,
    output logic abort_hit,
    output logic zero_hit
);

    logic [6:0] hist_r;
    logic [2:0] ones_r;
    logic [7:0] window_s;

    // Advance the bit history and the ones run on every bit cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= 7'd0;
            ones_r <= 3'd0;
        end else if (bit_en) begin
            hist_r <= window_s[7:1];
            ones_r <= ones_next(ones_r, rx_bit);
        end
    end

    // Classify the live bit; a flag wins over stuffed-zero removal
    always_comb begin
        window_s  = {rx_bit, hist_r};
        flag_hit  = 1'b0;
        abort_hit = 1'b0;
        zero_hit  = 1'b0;
        if (bit_en) begin
            flag_hit  = (window_s == HDLC_FLAG);
            abort_hit = rx_bit && (ones_r == 3'd6);
            zero_hit  = !rx_bit && (ones_r == 3'd5) && (window_s != HDLC_FLAG);
        end else begin
            flag_hit  = 1'b0;
            abort_hit = 1'b0;
            zero_hit  = 1'b0;
        end
    end

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: delays line bits so flag bits never reach the byte
// assembler, removes stuffed zeros, assembles bytes LSB first and tracks
// HUNT/SYNC/FRAME. The live line bit is the first delay stage, so a bit is
// committed seven bit cycles after it arrives.
// Optional: define HDLC_RX_OVERFLOW_EN to add FrameSize/Overflow and a
// per-frame limit of MAX_FRAME_BYTES bytes.
module hdlc_rx_deframer
    import hdlc_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RxEN,
    input  logic       Rx,
    output logic [7:0] RxData,
    output logic       NewByte,
    output logic       FlagDetect,
    output logic       AbortDetect,
    output logic       ZeroDetect,
    output logic       EoF,
    output logic       FrameError,
    output logic       ValidFrame
`ifdef HDLC_RX_OVERFLOW_EN
    ,
    output logic [7:0] FrameSize,
    output logic       Overflow
`endif
);

    rx_state_e  state_r;
    logic [6:0] pipe_d_r;
    logic [6:0] pipe_v_r;
    logic [6:0] asm_r;
    logic [2:0] bit_cnt_r;
    logic       flag_hit_s;
    logic       abort_hit_s;
    logic       zero_hit_s;
    logic       commit_s;
    logic       byte_done_s;
    logic       emit_s;
    logic       in_valid_s;
`ifdef HDLC_RX_OVERFLOW_EN
    logic [7:0] frame_size_r;
    logic       overflow_r;
`endif

    hdlc_rx_flag_detect u_flag_detect (
        .clk       (Clk),
        .rst_n     (Rst),
        .bit_en    (RxEN),
        .rx_bit    (Rx),
        .flag_hit  (flag_hit_s),
        .abort_hit (abort_hit_s),
        .zero_hit  (zero_hit_s)
    );

    // Decide whether the bit leaving the delay line is committed and whether it completes a byte
    always_comb begin
        commit_s    = RxEN && !flag_hit_s && pipe_v_r[6];
        byte_done_s = commit_s && (bit_cnt_r == 3'd7);
        in_valid_s  = (state_r != HUNT) && !zero_hit_s;
`ifdef HDLC_RX_OVERFLOW_EN
        if (byte_done_s && !overflow_r && (frame_size_r != MAX_FRAME_BYTES)) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
`else
        emit_s = byte_done_s;
`endif
    end

    // Receiver FSM with delay line, byte assembly and registered pulse outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r     <= HUNT;
            pipe_d_r    <= 7'd0;
            pipe_v_r    <= 7'd0;
            asm_r       <= 7'd0;
            bit_cnt_r   <= 3'd0;
            RxData      <= 8'h00;
            NewByte     <= 1'b0;
            FlagDetect  <= 1'b0;
            AbortDetect <= 1'b0;
            ZeroDetect  <= 1'b0;
            EoF         <= 1'b0;
            FrameError  <= 1'b0;
            ValidFrame  <= 1'b0;
`ifdef HDLC_RX_OVERFLOW_EN
            frame_size_r <= 8'd0;
            overflow_r   <= 1'b0;
`endif
        end else begin
            NewByte     <= 1'b0;
            FlagDetect  <= 1'b0;
            AbortDetect <= 1'b0;
            ZeroDetect  <= 1'b0;
            EoF         <= 1'b0;
            FrameError  <= 1'b0;
            if (RxEN) begin
                FlagDetect <= flag_hit_s;
                ZeroDetect <= zero_hit_s;
                pipe_d_r   <= {pipe_d_r[5:0], Rx};
                pipe_v_r   <= {pipe_v_r[5:0], in_valid_s};
                if (commit_s) begin
                    asm_r     <= {pipe_d_r[6], asm_r[6:1]};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                if (emit_s) begin
                    RxData  <= {pipe_d_r[6], asm_r};
                    NewByte <= 1'b1;
                end
`ifdef HDLC_RX_OVERFLOW_EN
                if (byte_done_s && !overflow_r) begin
                    if (frame_size_r == MAX_FRAME_BYTES) begin
                        overflow_r <= 1'b1;
                    end else begin
                        frame_size_r <= frame_size_r + 8'd1;
                    end
                end
`endif
                case (state_r)
                    HUNT: begin
                        if (flag_hit_s) begin
                            state_r <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (abort_hit_s) begin
                            state_r     <= HUNT;
                            AbortDetect <= 1'b1;
                        end else if (commit_s) begin
                            state_r    <= FRAME;
                            ValidFrame <= 1'b1;
                        end
                    end
                    FRAME: begin
                        if (flag_hit_s) begin
                            state_r    <= SYNC;
                            EoF        <= 1'b1;
                            FrameError <= (bit_cnt_r != 3'd0);
                            ValidFrame <= 1'b0;
                        end else if (abort_hit_s) begin
                            state_r     <= HUNT;
                            AbortDetect <= 1'b1;
                            ValidFrame  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r    <= HUNT;
                        ValidFrame <= 1'b0;
                    end
                endcase
                // A flag or an abort discards everything still in flight
                if (flag_hit_s || (abort_hit_s && (state_r != HUNT))) begin
                    pipe_v_r  <= 7'd0;
                    bit_cnt_r <= 3'd0;
`ifdef HDLC_RX_OVERFLOW_EN
                    overflow_r <= 1'b0;
                    if (flag_hit_s) begin
                        frame_size_r <= 8'd0;
                    end
`endif
                end
            end
        end
    end

`ifdef HDLC_RX_OVERFLOW_EN
    assign FrameSize = frame_size_r;
    assign Overflow  = overflow_r;
`endif

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench for hdlc_rx_deframer: frames are described as bit lists,
// the expected bytes / end-of-frame results are derived from frame content
// and queued, and a monitor compares every DUT pulse against the queues.
module tb_hdlc_rx_deframer;

    typedef bit bitq_t[$];

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       RxEN = 1'b0;
    logic       Rx = 1'b0;
    logic [7:0] RxData;
    logic       NewByte, FlagDetect, AbortDetect, ZeroDetect, EoF, FrameError, ValidFrame;
`ifdef HDLC_RX_OVERFLOW_EN
    logic [7:0] FrameSize;
    logic       Overflow;
`endif

    hdlc_rx_deframer dut (
        .Clk(Clk), .Rst(Rst), .RxEN(RxEN), .Rx(Rx),
        .RxData(RxData), .NewByte(NewByte), .FlagDetect(FlagDetect),
        .AbortDetect(AbortDetect), .ZeroDetect(ZeroDetect), .EoF(EoF),
        .FrameError(FrameError), .ValidFrame(ValidFrame)
`ifdef HDLC_RX_OVERFLOW_EN
        , .FrameSize(FrameSize), .Overflow(Overflow)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int fails = 0;
    logic [7:0] exp_bytes[$];
    bit exp_fe[$];
    int exp_flags = 0, exp_aborts = 0, exp_zeros = 0;
    int act_flags = 0, act_aborts = 0, act_zeros = 0;
    int gap_mode = 0;
    int tx_ones = 0;
    bit need_open = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: compares every output pulse against the scoreboard queues
    always @(negedge Clk) begin
        if (Rst) begin
            if (NewByte) begin
                if (exp_bytes.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL newbyte_unexpected: got RxData=%02h, required no byte", RxData);
                end else begin
                    check("rxdata", {24'd0, RxData}, {24'd0, exp_bytes.pop_front()});
                end
            end
            if (EoF) begin
                if (exp_fe.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL eof_unexpected: got EoF=1, required no end of frame");
                end else begin
                    check("frame_error", {31'd0, FrameError}, {31'd0, exp_fe.pop_front()});
                end
            end
            if (FrameError) check("fe_needs_eof", {31'd0, EoF}, 32'd1);
            if (EoF || AbortDetect) check("validframe_drop", {31'd0, ValidFrame}, 32'd0);
            if (FlagDetect) act_flags++;
            if (AbortDetect) act_aborts++;
            if (ZeroDetect) act_zeros++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic bitq_t add_byte(input bitq_t q, input logic [7:0] v);
        bitq_t r;
        r = q;
        for (int i = 0; i < 8; i++) r.push_back(v[i]);
        return r;
    endfunction

    task automatic drive_bit(input logic b);
        int g;
        g = (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
        repeat (g) @(negedge Clk);
        RxEN = 1'b1;
        Rx = b;
        @(negedge Clk);
        RxEN = 1'b0;
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) drive_bit(f[i]);
        exp_flags++;
        tx_ones = 0;
    endtask

    task automatic send_bits(input bitq_t q);
        for (int i = 0; i < q.size(); i++) begin
            drive_bit(q[i]);
            if (q[i]) tx_ones++;
            else tx_ones = 0;
            if (tx_ones == 5) begin
                drive_bit(1'b0);
                exp_zeros++;
                tx_ones = 0;
            end
        end
    endtask

    // Queue the expected results of one frame, then transmit it
    task automatic run_frame(input bitq_t bits, input bit abort_end);
        int n;
        logic [7:0] v;
        n = bits.size();
        if (abort_end && n > 0) bits[n-1] = 1'b0;
        if (need_open) send_flag();
        for (int k = 0; k < n / 8; k++) begin
            for (int j = 0; j < 8; j++) v[j] = bits[8*k + j];
            exp_bytes.push_back(v);
        end
        if (!abort_end && n > 0) exp_fe.push_back((n % 8) != 0);
        send_bits(bits);
        if (abort_end) begin
            repeat (7) drive_bit(1'b1);
            exp_aborts++;
            tx_ones = 0;
            need_open = 1'b1;
        end else begin
            send_flag();
            need_open = 1'b0;
        end
    endtask

    initial begin
        bitq_t q;
        int n;
        repeat (3) @(negedge Clk);
        check("rst_rxdata", {24'd0, RxData}, 32'd0);
        check("rst_newbyte", {31'd0, NewByte}, 32'd0);
        check("rst_validframe", {31'd0, ValidFrame}, 32'd0);
        check("rst_eof", {31'd0, EoF}, 32'd0);
        check("rst_flag", {31'd0, FlagDetect}, 32'd0);
        Rst = 1'b1;
        @(negedge Clk);

        q = {}; q = add_byte(q, 8'hA5); run_frame(q, 1'b0);
        q = {}; q = add_byte(q, 8'h3F); run_frame(q, 1'b0);
        q = {}; q = add_byte(q, 8'h12); run_frame(q, 1'b1);
        q = {}; q = add_byte(q, 8'hA5); q = add_byte(q, 8'h03);
        while (q.size() > 12) void'(q.pop_back());
        run_frame(q, 1'b0);

        gap_mode = 1;
        q = {}; q = add_byte(q, 8'h5A); q = add_byte(q, 8'hC3); run_frame(q, 1'b0);
        q = {}; q = add_byte(q, 8'h7E); run_frame(q, 1'b0);
        gap_mode = 0;

        for (int f = 0; f < 30; f++) begin
            q = {};
            if ($urandom_range(0, 1) == 1) n = 8 * int'($urandom_range(0, 4));
            else n = int'($urandom_range(1, 39));
            for (int i = 0; i < n; i++) q.push_back(1'($urandom_range(0, 1)));
            run_frame(q, $urandom_range(0, 3) == 0);
        end

`ifdef HDLC_RX_OVERFLOW_EN
        if (need_open) send_flag();
        q = {};
        for (int k = 0; k < 130; k++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            q = add_byte(q, v);
            if (k < 128) exp_bytes.push_back(v);
        end
        exp_fe.push_back(1'b0);
        send_bits(q);
        repeat (4) @(negedge Clk);
        check("overflow_set", {31'd0, Overflow}, 32'd1);
        check("framesize_max", {24'd0, FrameSize}, 32'd128);
        send_flag();
        need_open = 1'b0;
        repeat (12) @(negedge Clk);
        check("overflow_clear", {31'd0, Overflow}, 32'd0);
        check("framesize_clear", {24'd0, FrameSize}, 32'd0);
`endif

        // Abandon a frame with reset while inside it
        send_flag();
        q = {}; q = add_byte(q, 8'hA5); q = add_byte(q, 8'h05);
        while (q.size() > 12) void'(q.pop_back());
        send_bits(q);
        repeat (2) @(negedge Clk);
        check("validframe_mid", {31'd0, ValidFrame}, 32'd1);
        Rst = 1'b0;
        @(negedge Clk);
        check("midrst_validframe", {31'd0, ValidFrame}, 32'd0);
        check("midrst_rxdata", {24'd0, RxData}, 32'd0);
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        tx_ones = 0;
        for (int i = 0; i < 20; i++) drive_bit(1'b0);
        repeat (20) @(negedge Clk);

        check("bytes_left", exp_bytes.size(), 32'd0);
        check("eof_left", exp_fe.size(), 32'd0);
        check("flag_count", act_flags, exp_flags);
        check("abort_count", act_aborts, exp_aborts);
        check("zero_count", act_zeros, exp_zeros);
        check("end_validframe", {31'd0, ValidFrame}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
